bias_loader: RTL and testbench

// - Writer side of the bias-RF write port (w_index/w_data/w_en) of the SIMD bias+ReLU stage.
// - On a start pulse, fetches ARRAY_N packed bias values from the on-chip buffer, one memory word at a time.
// - Unpacks each word and issues one bias write per cycle, then pulses done.
// - Sits between the NPU controller/buffer and the bias+ReLU SIMD unit; runs once per output-channel tile.

---
 rtl/bias_loader_pkg.sv | 16 +
 rtl/bias_word_unpack.sv | 37 +++
 rtl/bias_loader.sv | 131 +++++++++++++
 tb/tb_bias_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_loader_pkg.sv
// Shared definitions for the bias loader: FSM state encoding and sizing helpers.
package bias_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UNPACK = 3'd3,
        ST_DONE   = 3'd4
    } bl_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/bias_word_unpack.sv
// Holds one fetched bias word and presents its lanes one at a time, lane 0 first.
module bias_word_unpack #(
    parameter int OUT_WIDTH     = 32,
    parameter int BIAS_PER_WORD = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_load,
    input  logic [BIAS_PER_WORD*OUT_WIDTH-1:0] i_word,
    input  logic                               i_shift,
    output logic [OUT_WIDTH-1:0]               o_lane,
    output logic                               o_last_lane
);
    localparam int WORD_W = BIAS_PER_WORD * OUT_WIDTH;
    localparam int LCNT_W = (BIAS_PER_WORD > 1) ? $clog2(BIAS_PER_WORD) : 1;

    logic [WORD_W-1:0] r_word;
    logic [LCNT_W-1:0] r_lane_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word     <= '0;
            r_lane_cnt <= '0;
        end else if (i_load) begin
            r_word     <= i_word;
            r_lane_cnt <= '0;
        end else if (i_shift) begin
            // Shifting keeps the active lane in the low slice, so o_lane is a plain register tap.
            r_word     <= r_word >> OUT_WIDTH;
            r_lane_cnt <= r_lane_cnt + LCNT_W'(1);
        end
    end

    assign o_lane      = r_word[OUT_WIDTH-1:0];
    assign o_last_lane = (r_lane_cnt == LCNT_W'(BIAS_PER_WORD - 1));

endmodule

// File: rtl/bias_loader.sv
// Fetches ARRAY_N packed biases from the buffer one word at a time and writes them
// into the bias register file, one lane per cycle, then pulses done.
module bias_loader
    import bias_loader_pkg::*;
#(
    parameter int ARRAY_N       = 16,
    parameter int OUT_WIDTH     = 32,
    parameter int BIAS_PER_WORD = 4,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    output logic                               busy,
    output logic                               done,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr,
    input  logic                               mem_rsp_valid,
    input  logic [BIAS_PER_WORD*OUT_WIDTH-1:0] mem_rsp_data,
    output logic [$clog2(ARRAY_N):0]           w_index,
    output logic [OUT_WIDTH-1:0]               w_data,
    output logic                               w_en
);
    localparam int NWORDS = ceil_div(ARRAY_N, BIAS_PER_WORD);
    localparam int IDX_W  = $clog2(ARRAY_N) + 1;
    localparam int WORD_W = $clog2(NWORDS + 1);

    bl_state_t             r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_req_valid;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic                  r_w_en;
    logic [IDX_W-1:0]      r_w_index;
    logic [WORD_W-1:0]     r_word_j;

    logic                  w_load;
    logic                  w_shift;
    logic                  w_last_lane;
    logic                  w_last_bias;
    logic [OUT_WIDTH-1:0]  w_lane;

    assign w_load      = (r_state == ST_WAIT) && mem_rsp_valid;
    assign w_last_bias = (r_w_index == IDX_W'(ARRAY_N - 1));
    assign w_shift     = (r_state == ST_UNPACK) && !w_last_lane && !w_last_bias;

    bias_word_unpack #(
        .OUT_WIDTH    (OUT_WIDTH),
        .BIAS_PER_WORD(BIAS_PER_WORD)
    ) u_unpack (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_word     (mem_rsp_data),
        .i_shift    (w_shift),
        .o_lane     (w_lane),
        .o_last_lane(w_last_lane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_w_en      <= 1'b0;
            r_w_index   <= '0;
            r_word_j    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= ST_REQ;
                        r_busy      <= 1'b1;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= base_addr;
                        r_word_j    <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // First lane goes out in the same edge the word is captured.
                    if (mem_rsp_valid) begin
                        r_state   <= ST_UNPACK;
                        r_w_en    <= 1'b1;
                        r_w_index <= IDX_W'(r_word_j * BIAS_PER_WORD);
                    end
                end
                ST_UNPACK: begin
                    if (w_last_bias) begin
                        r_w_en  <= 1'b0;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_last_lane) begin
                        r_w_en      <= 1'b0;
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= r_req_addr + ADDR_WIDTH'(1);
                        r_word_j    <= r_word_j + WORD_W'(1);
                    end else begin
                        r_w_index <= r_w_index + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign w_en          = r_w_en;
    assign w_index       = r_w_index;
    assign w_data        = w_lane;

endmodule

// File: tb/tb_bias_loader.sv
// Scoreboard bench for bias_loader: default geometry plus a 3-bias-per-word instance.
module tb_bias_loader;
    localparam int AN   = 16;
    localparam int OW   = 32;
    localparam int BPW  = 4;
    localparam int BPW3 = 3;
    localparam int AW   = 16;
    localparam int IW   = $clog2(AN) + 1;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [OW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default geometry
    logic              start, busy, done, mem_req_valid, mem_req_ready, mem_rsp_valid, w_en;
    logic [AW-1:0]     base_addr, mem_req_addr;
    logic [BPW*OW-1:0] mem_rsp_data;
    logic [IW-1:0]     w_index;
    logic [OW-1:0]     w_data;

    // Instance B: three biases per word, partial last word
    logic               start_b, busy_b, done_b, mem_req_valid_b, mem_req_ready_b, mem_rsp_valid_b, w_en_b;
    logic [AW-1:0]      base_addr_b, mem_req_addr_b;
    logic [BPW3*OW-1:0] mem_rsp_data_b;
    logic [IW-1:0]      w_index_b;
    logic [OW-1:0]      w_data_b;

    bias_loader #(.ARRAY_N(AN), .OUT_WIDTH(OW), .BIAS_PER_WORD(BPW), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .w_index(w_index), .w_data(w_data), .w_en(w_en)
    );

    bias_loader #(.ARRAY_N(AN), .OUT_WIDTH(OW), .BIAS_PER_WORD(BPW3), .ADDR_WIDTH(AW)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_addr_b), .busy(busy_b), .done(done_b),
        .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready_b), .mem_req_addr(mem_req_addr_b),
        .mem_rsp_valid(mem_rsp_valid_b), .mem_rsp_data(mem_rsp_data_b),
        .w_index(w_index_b), .w_data(w_data_b), .w_en(w_en_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory word at address a, relative to load base b: lane k holds 100*j+k.
    function automatic logic [127:0] mk_word(input logic [AW-1:0] a, input logic [AW-1:0] b, input int bpw);
        logic [127:0]  w;
        logic [AW-1:0] d;
        int            j;
        w = '0;
        d = a - b;
        j = int'(d);
        for (int k = 0; k < bpw; k++) w[k*OW +: OW] = OW'(100 * j + k);
        return w;
    endfunction

    // ---------------- memory model A ----------------
    int            stall_cycles = 0;
    bit            rand_lat     = 0;
    bit            stray_en     = 0;
    logic [AW-1:0] tb_base      = '0;
    int            stall_cnt    = 0;
    int            lat_cnt      = 0;
    bit            pend         = 0;
    logic [AW-1:0] pend_addr    = '0;

    always @(posedge clk) begin
        #1;
        mem_rsp_valid = 1'b0;
        if (pend) begin
            if (lat_cnt <= 1) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mk_word(pend_addr, tb_base, BPW);
                pend          = 0;
            end else begin
                lat_cnt--;
            end
        end else if (stray_en && $urandom_range(3) == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid && !pend) begin
            if (stall_cnt < stall_cycles) begin
                stall_cnt++;
            end else begin
                mem_req_ready = 1'b1;
                pend          = 1;
                pend_addr     = mem_req_addr;
                lat_cnt       = rand_lat ? int'($urandom_range(8, 1)) : 1;
                stall_cnt     = 0;
            end
        end
    end

    // ---------------- memory model B (ready=1, latency 1) ----------------
    logic [AW-1:0] tb_base_b = '0;
    bit            pend_b    = 0;
    logic [AW-1:0] pend_addr_b = '0;
    logic [127:0]  word_b;

    always @(posedge clk) begin
        #1;
        mem_req_ready_b = 1'b1;
        mem_rsp_valid_b = pend_b;
        if (pend_b) begin
            word_b         = mk_word(pend_addr_b, tb_base_b, BPW3);
            mem_rsp_data_b = word_b[BPW3*OW-1:0];
        end
        pend_b = 0;
        if (mem_req_valid_b) begin
            pend_b      = 1;
            pend_addr_b = mem_req_addr_b;
        end
    end

    // ---------------- monitors / scoreboards ----------------
    wr_t           wr_q[$];
    wr_t           wr_q_b[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] addr_q_b[$];
    int            wr_cnt = 0, done_cnt = 0, req_cnt = 0;
    int            wr_cnt_b = 0, done_cnt_b = 0, req_cnt_b = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;
    wr_t           e_a, e_b;
    logic [AW-1:0] a_a, a_b;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("req_hold_valid", 64'(mem_req_valid), 64'd1);
                check("req_hold_addr", 64'(mem_req_addr), 64'(prev_addr));
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
            if (mem_req_valid && mem_req_ready) begin
                req_cnt++;
                $display("A req addr=%04h", mem_req_addr);
                if (addr_q.size() == 0) check("extra_req", 64'(mem_req_valid), 64'd0);
                else begin
                    a_a = addr_q.pop_front();
                    check("req_addr", 64'(mem_req_addr), 64'(a_a));
                end
            end
            if (w_en) begin
                wr_cnt++;
                $display("A wr idx=%0d data=%0d", w_index, w_data);
                if (wr_q.size() == 0) check("extra_wen", 64'(w_en), 64'd0);
                else begin
                    e_a = wr_q.pop_front();
                    check("w_index", 64'(w_index), 64'(e_a.idx));
                    check("w_data", 64'(w_data), 64'(e_a.data));
                end
            end
            if (done) done_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req_valid_b && mem_req_ready_b) begin
                req_cnt_b++;
                $display("B req addr=%04h", mem_req_addr_b);
                if (addr_q_b.size() == 0) check("b_extra_req", 64'(mem_req_valid_b), 64'd0);
                else begin
                    a_b = addr_q_b.pop_front();
                    check("b_req_addr", 64'(mem_req_addr_b), 64'(a_b));
                end
            end
            if (w_en_b) begin
                wr_cnt_b++;
                $display("B wr idx=%0d data=%0d", w_index_b, w_data_b);
                if (wr_q_b.size() == 0) check("b_extra_wen", 64'(w_en_b), 64'd0);
                else begin
                    e_b = wr_q_b.pop_front();
                    check("b_w_index", 64'(w_index_b), 64'(e_b.idx));
                    check("b_w_data", 64'(w_data_b), 64'(e_b.data));
                end
            end
            if (done_b) done_cnt_b++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_load(input logic [AW-1:0] base, input bit repulse, input int reset_after);
        int  wr0, dn0, rq0, cyc;
        bit  hit_reset;
        wr_t e;
        wr0 = wr_cnt; dn0 = done_cnt; rq0 = req_cnt; hit_reset = 0;
        for (int i = 0; i < AN; i++) begin
            e.idx  = IW'(i);
            e.data = OW'(100 * (i / BPW) + (i % BPW));
            wr_q.push_back(e);
        end
        for (int j = 0; j < (AN + BPW - 1) / BPW; j++) addr_q.push_back(base + AW'(j));
        tb_base = base;
        @(negedge clk); #1;
        start = 1'b1; base_addr = base;
        @(negedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom());
        cyc = 0;
        while (done_cnt == dn0 && cyc < 3000) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 2) check("busy_mid", 64'(busy), 64'd1);
            start = repulse && (cyc == 8 || cyc == 20);
            if (reset_after > 0 && wr_cnt - wr0 == reset_after) begin
                hit_reset = 1;
                break;
            end
        end
        start = 1'b0;
        if (hit_reset) begin
            reset = 1'b1;
            wr_q.delete();
            addr_q.delete();
            @(negedge clk); #1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_wen", 64'(w_en), 64'd0);
            check("rst_req_valid", 64'(mem_req_valid), 64'd0);
            reset = 1'b0;
            repeat (15) @(negedge clk);
            #1;
            check("rst_no_done", 64'(done_cnt - dn0), 64'd0);
            check("rst_writes", 64'(wr_cnt - wr0), 64'(reset_after));
        end else begin
            if (repulse) begin
                start = 1'b1;
                @(negedge clk); #1;
                start = 1'b0;
            end
            check("done_seen", 64'(done_cnt - dn0), 64'd1);
            repeat (30) @(negedge clk);
            #1;
            check("writes", 64'(wr_cnt - wr0), 64'(AN));
            check("reqs", 64'(req_cnt - rq0), 64'((AN + BPW - 1) / BPW));
            check("done_once", 64'(done_cnt - dn0), 64'd1);
            check("busy_after", 64'(busy), 64'd0);
            check("wq_left", 64'(wr_q.size()), 64'd0);
        end
    endtask

    task automatic run_b(input logic [AW-1:0] base);
        int  cyc;
        wr_t e;
        for (int i = 0; i < AN; i++) begin
            e.idx  = IW'(i);
            e.data = OW'(100 * (i / BPW3) + (i % BPW3));
            wr_q_b.push_back(e);
        end
        for (int j = 0; j < 6; j++) addr_q_b.push_back(base + AW'(j));
        tb_base_b = base;
        @(negedge clk); #1;
        start_b = 1'b1; base_addr_b = base;
        @(negedge clk); #1;
        start_b = 1'b0;
        cyc = 0;
        while (done_cnt_b == 0 && cyc < 3000) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("b_done_seen", 64'(done_cnt_b), 64'd1);
        repeat (20) @(negedge clk);
        #1;
        check("b_writes", 64'(wr_cnt_b), 64'(AN));
        check("b_reqs", 64'(req_cnt_b), 64'd6);
        check("b_done_once", 64'(done_cnt_b), 64'd1);
        check("b_busy_after", 64'(busy_b), 64'd0);
        check("b_wq_left", 64'(wr_q_b.size()), 64'd0);
    endtask

    initial begin
        start = 1'b1;              // start held during reset must be ignored
        base_addr = 16'h0abc;
        start_b = 1'b0;
        base_addr_b = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        mem_req_ready_b = 1'b1; mem_rsp_valid_b = 1'b0; mem_rsp_data_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy0", 64'(busy), 64'd0);
        check("rst_done0", 64'(done), 64'd0);
        check("rst_req_valid0", 64'(mem_req_valid), 64'd0);
        check("rst_req_addr0", 64'(mem_req_addr), 64'd0);
        check("rst_wen0", 64'(w_en), 64'd0);
        check("rst_windex0", 64'(w_index), 64'd0);
        check("rst_wdata0", 64'(w_data), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk); #1;
        check("start_with_reset", 64'(busy), 64'd0);

        run_load(16'h0010, 0, 0);
        stall_cycles = 5;
        run_load(16'h1234, 0, 0);
        stall_cycles = 0;
        rand_lat = 1; stray_en = 1;
        run_load(16'h0200, 0, 0);
        run_load(16'h0300, 1, 0);
        rand_lat = 0; stray_en = 0;
        run_load(16'h0400, 0, 6);
        run_load(16'hfffe, 0, 0);
        run_b(16'h0050);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
